// File: rtl/psg_pkg.sv
// Shared definitions for the PSG bus master: bus-mode encoding, FSM states and the queued request record.
package psg_pkg;

    localparam logic [1:0] PSG_BUS_INACT = 2'b00;
    localparam logic [1:0] PSG_BUS_READ  = 2'b01;
    localparam logic [1:0] PSG_BUS_WRITE = 2'b10;
    localparam logic [1:0] PSG_BUS_ADDR  = 2'b11;

    typedef enum logic [2:0] {
        PSG_IDLE,
        PSG_ADDR,
        PSG_GAP1,
        PSG_DATA,
        PSG_GAP2
    } psg_state_t;

    typedef struct packed {
        logic       rd;
        logic [3:0] reg_idx;
        logic [7:0] dat;
    } psg_req_t;

    localparam int PSG_REQ_W = $bits(psg_req_t);

endpackage

// File: rtl/psg_req_fifo.sv
// Synchronous request FIFO for the PSG bus master; DEPTH must be a power of two.
module psg_req_fifo
    import psg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 MCLK,
    input  logic                 RESET_L,
    input  logic                 push,
    input  logic [PSG_REQ_W-1:0] push_data,
    input  logic                 pop,
    output logic [PSG_REQ_W-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);

    logic [PSG_REQ_W-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge MCLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/psg_bus_master.sv
// PSG bus master: queues register requests and plays them onto the BDIR/BC1 bus, paced by ENA.
// Define PSG_READBACK_EN to build the register read path; otherwise every request is a write.
module psg_bus_master
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic       MCLK,
    input  logic       RESET_L,
    input  logic       ENA,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_RD,
    input  logic [3:0] REQ_REG,
    input  logic [7:0] REQ_DAT,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DAT,
    output logic [7:0] PSG_DO,
    input  logic [7:0] PSG_DI,
    output logic       PSG_BDIR,
    output logic       PSG_BC1,
    output logic       BUSY
);
    localparam logic [3:0] LAST_TICK = 4'(HOLD_TICKS - 1);

    psg_state_t state;
    psg_req_t   cur;
    psg_req_t   head;
    psg_req_t   incoming;
    logic [3:0] tick;
    logic [1:0] bus_mode;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       phase_done;

`ifdef PSG_READBACK_EN
    assign incoming = '{rd: REQ_RD, reg_idx: REQ_REG, dat: REQ_DAT};
`else
    assign incoming = '{rd: 1'b0, reg_idx: REQ_REG, dat: REQ_DAT};
`endif

    // A full queue still accepts when the head leaves in the same cycle.
    assign pop        = (state == PSG_IDLE) && !fifo_empty;
    assign REQ_READY  = RESET_L && (!fifo_full || pop);
    assign push       = REQ_VALID && REQ_READY;
    assign BUSY       = !fifo_empty || (state != PSG_IDLE);
    assign phase_done = ENA && (tick == LAST_TICK);
    assign {PSG_BDIR, PSG_BC1} = bus_mode;

    psg_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .MCLK      (MCLK),
        .RESET_L   (RESET_L),
        .push      (push),
        .push_data (incoming),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state    <= PSG_IDLE;
            cur      <= '0;
            tick     <= '0;
            bus_mode <= PSG_BUS_INACT;
            PSG_DO   <= 8'h00;
        end else begin
            case (state)
                PSG_IDLE: if (pop) begin
                    cur      <= head;
                    tick     <= '0;
                    bus_mode <= PSG_BUS_ADDR;
                    PSG_DO   <= {4'h0, head.reg_idx};
                    state    <= PSG_ADDR;
                end
                PSG_ADDR: if (phase_done) begin
                    tick     <= '0;
                    bus_mode <= PSG_BUS_INACT;
                    PSG_DO   <= 8'h00;
                    state    <= PSG_GAP1;
                end else if (ENA) begin
                    tick <= tick + 4'd1;
                end
                PSG_GAP1: if (ENA) begin
                    bus_mode <= cur.rd ? PSG_BUS_READ : PSG_BUS_WRITE;
                    PSG_DO   <= cur.rd ? 8'h00 : cur.dat;
                    state    <= PSG_DATA;
                end
                PSG_DATA: if (phase_done) begin
                    tick     <= '0;
                    bus_mode <= PSG_BUS_INACT;
                    PSG_DO   <= 8'h00;
                    state    <= PSG_GAP2;
                end else if (ENA) begin
                    tick <= tick + 4'd1;
                end
                PSG_GAP2: if (ENA) begin
                    state <= PSG_IDLE;
                end
                default: state <= PSG_IDLE;
            endcase
        end
    end

`ifdef PSG_READBACK_EN
    logic read_done;

    // The PSG drives O_DA during the read phase; capture it on the tick that ends the phase.
    assign read_done = (state == PSG_DATA) && phase_done && cur.rd;

    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            RSP_VALID <= 1'b0;
            RSP_DAT   <= 8'h00;
        end else begin
            RSP_VALID <= read_done;
            if (read_done) RSP_DAT <= PSG_DI;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{REQ_RD, PSG_DI};
    assign RSP_VALID     = 1'b0;
    assign RSP_DAT       = 8'h00;
`endif

endmodule

// File: tb/tb_psg_bus_master.sv
// Self-checking bench for psg_bus_master: per-cycle compare against a transaction-level model,
// plus directed traces with hand-computed expectations.
module tb_psg_bus_master;

    localparam int FIFO_DEPTH = 4;
    localparam int HOLD       = 2;
`ifdef PSG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       MCLK;
    logic       RESET_L;
    logic       ENA;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_RD;
    logic [3:0] REQ_REG;
    logic [7:0] REQ_DAT;
    logic       RSP_VALID;
    logic [7:0] RSP_DAT;
    logic [7:0] PSG_DO;
    logic [7:0] PSG_DI;
    logic       PSG_BDIR;
    logic       PSG_BC1;
    logic       BUSY;

    psg_bus_master #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_TICKS (HOLD)
    ) dut (
        .MCLK      (MCLK),
        .RESET_L   (RESET_L),
        .ENA       (ENA),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_RD    (REQ_RD),
        .REQ_REG   (REQ_REG),
        .REQ_DAT   (REQ_DAT),
        .RSP_VALID (RSP_VALID),
        .RSP_DAT   (RSP_DAT),
        .PSG_DO    (PSG_DO),
        .PSG_DI    (PSG_DI),
        .PSG_BDIR  (PSG_BDIR),
        .PSG_BC1   (PSG_BC1),
        .BUSY      (BUSY)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ENA / PSG_DI generator: fixed period, random, or frozen low.
    int  ena_period = 8;
    int  ena_cnt    = 0;
    bit  ena_stop   = 1'b0;
    bit  ena_rand   = 1'b0;
    bit  di_force   = 1'b0;

    initial begin
        ENA    = 1'b0;
        PSG_DI = 8'h00;
        forever begin
            @(negedge MCLK);
            #1;
            PSG_DI = di_force ? 8'hA5 : 8'($urandom);
            if (ena_stop) begin
                ENA = 1'b0;
            end else if (ena_rand) begin
                ENA = ($urandom_range(0, 2) == 0);
            end else begin
                ena_cnt++;
                if (ena_cnt >= ena_period) begin
                    ena_cnt = 0;
                    ENA     = 1'b1;
                end else begin
                    ENA = 1'b0;
                end
            end
        end
    end

    // Transaction-level model: a queue of requests and, for the active one, a list of bus phases.
    typedef struct {
        logic       rd;
        logic [3:0] r;
        logic [7:0] d;
    } mreq_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] dout;
        int         ticks;
    } phase_t;

    mreq_t      mq[$];
    mreq_t      nr;
    mreq_t      hd;
    phase_t     ph[4];
    bit         m_active = 1'b0;
    bit         m_cur_rd = 1'b0;
    bit         m_rsp_v  = 1'b0;
    logic [7:0] m_rsp_d  = 8'h00;
    int         m_p      = 0;
    int         m_tl     = 0;
    bit         pop_now;
    bit         ready_now;

    always @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            mq.delete();
            m_active = 1'b0;
            m_rsp_v  = 1'b0;
            m_rsp_d  = 8'h00;
        end else begin
            pop_now   = !m_active && (mq.size() != 0);
            ready_now = (mq.size() < FIFO_DEPTH) || pop_now;
            m_rsp_v   = 1'b0;
            if (m_active && ENA) begin
                m_tl--;
                if (m_tl == 0) begin
                    if (m_p == 2 && m_cur_rd) begin
                        m_rsp_v = 1'b1;
                        m_rsp_d = PSG_DI;
                    end
                    m_p++;
                    if (m_p == 4) m_active = 1'b0;
                    else          m_tl = ph[m_p].ticks;
                end
            end
            if (pop_now) begin
                hd    = mq.pop_front();
                ph[0] = '{2'b11, {4'h0, hd.r}, HOLD};
                ph[1] = '{2'b00, 8'h00, 1};
                ph[2] = hd.rd ? '{2'b01, 8'h00, HOLD} : '{2'b10, hd.d, HOLD};
                ph[3] = '{2'b00, 8'h00, 1};
                m_cur_rd = hd.rd;
                m_p      = 0;
                m_tl     = HOLD;
                m_active = 1'b1;
            end
            if (REQ_VALID && ready_now) begin
                nr.rd = READBACK ? REQ_RD : 1'b0;
                nr.r  = REQ_REG;
                nr.d  = REQ_DAT;
                mq.push_back(nr);
            end
        end
    end

    // Compare process plus trace recorder (segments of constant bus state, ENA ticks per segment).
    logic [1:0]  exp_mode;
    logic [7:0]  exp_do;
    logic        exp_busy;
    logic        exp_ready;
    logic [10:0] cur_seg;
    logic [10:0] seg_val[$];
    int          seg_ena[$];
    logic [7:0]  wr_log[$];
    logic [1:0]  last_mode = 2'b00;
    bit          rec_on    = 1'b0;
    int          rsp_seen  = 0;

    always @(negedge MCLK) begin
        exp_mode  = 2'b00;
        exp_do    = 8'h00;
        if (m_active) begin
            exp_mode = ph[m_p].mode;
            exp_do   = ph[m_p].dout;
        end
        exp_busy  = m_active || (mq.size() != 0);
        exp_ready = RESET_L && ((mq.size() < FIFO_DEPTH) || (!m_active && mq.size() != 0));
        check("bus_mode",  32'({PSG_BDIR, PSG_BC1}), 32'(exp_mode));
        check("psg_do",    32'(PSG_DO),    32'(exp_do));
        check("busy",      32'(BUSY),      32'(exp_busy));
        check("req_ready", 32'(REQ_READY), 32'(exp_ready));
        check("rsp_valid", 32'(RSP_VALID), 32'(m_rsp_v));
        check("rsp_dat",   32'(RSP_DAT),   32'(m_rsp_d));

        if (RSP_VALID) rsp_seen++;
        if ({PSG_BDIR, PSG_BC1} == 2'b10 && last_mode != 2'b10) wr_log.push_back(PSG_DO);
        last_mode = {PSG_BDIR, PSG_BC1};

        if (rec_on) begin
            if (ENA && seg_val.size() != 0) seg_ena[seg_ena.size()-1]++;
            cur_seg = {PSG_BDIR, PSG_BC1, PSG_DO, BUSY};
            if (seg_val.size() == 0 || cur_seg != seg_val[seg_val.size()-1]) begin
                seg_val.push_back(cur_seg);
                seg_ena.push_back(0);
            end
        end
    end

    function automatic logic [10:0] seg(input logic [1:0] m, input logic [7:0] d, input logic b);
        return {m, d, b};
    endfunction

    task automatic send(input logic rd, input logic [3:0] r, input logic [7:0] d);
        logic rdy;
        bit   ok = 1'b0;
        int   n  = 0;
        @(negedge MCLK);
        #1;
        REQ_VALID = 1'b1;
        REQ_RD    = rd;
        REQ_REG   = r;
        REQ_DAT   = d;
        while (!ok && n < 3000) begin
            rdy = REQ_READY;
            @(posedge MCLK);
            if (rdy) begin
                ok = 1'b1;
            end else begin
                @(negedge MCLK);
                #1;
                n++;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drop_valid();
        @(negedge MCLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (BUSY && n < max_cycles) begin
            @(negedge MCLK);
            n++;
        end
        check("idle_timeout", 32'(BUSY), 32'd0);
    endtask

    task automatic run_txn(input logic rd, input logic [3:0] r, input logic [7:0] d);
        send(rd, r, d);
        seg_val.delete();
        seg_ena.delete();
        rec_on = 1'b1;
        drop_valid();
        wait_idle(2000);
        @(negedge MCLK);
        #1;
        rec_on = 1'b0;
    endtask

    // Expected trace of one isolated transaction with HOLD_TICKS = 2.
    task automatic check_txn(input logic [1:0] dmode, input logic [3:0] r, input logic [7:0] d);
        logic [10:0] ev[6];
        int          ee[6];
        ev = '{seg(2'b00, 8'h00, 1'b1), seg(2'b11, {4'h0, r}, 1'b1), seg(2'b00, 8'h00, 1'b1),
               seg(dmode, d, 1'b1),      seg(2'b00, 8'h00, 1'b1),     seg(2'b00, 8'h00, 1'b0)};
        ee = '{0, 2, 1, 2, 1, 0};
        check("trace_segments", 32'(seg_val.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seg_val.size()) begin
                check("trace_value", 32'(seg_val[i]), 32'(ev[i]));
                if (i >= 1 && i <= 4) check("trace_ena_ticks", 32'(seg_ena[i]), 32'(ee[i]));
            end
        end
    endtask

    int changes;
    int n_wait;
    logic [9:0] snap;

    initial begin
        RESET_L   = 1'b0;
        REQ_VALID = 1'b0;
        REQ_RD    = 1'b0;
        REQ_REG   = 4'h0;
        REQ_DAT   = 8'h00;
        repeat (3) @(negedge MCLK);
        #1;
        check("reset_mode",  32'({PSG_BDIR, PSG_BC1}), 32'd0);
        check("reset_do",    32'(PSG_DO),    32'd0);
        check("reset_busy",  32'(BUSY),      32'd0);
        check("reset_ready", 32'(REQ_READY), 32'd0);
        check("reset_rsp",   32'({RSP_VALID, RSP_DAT}), 32'd0);
        RESET_L = 1'b1;
        repeat (2) @(negedge MCLK);

        // Write reg 7 = 0x38, ENA every 8 MCLK.
        ena_period = 8;
        run_txn(1'b0, 4'd7, 8'h38);
        check_txn(2'b10, 4'd7, 8'h38);

`ifdef PSG_READBACK_EN
        di_force = 1'b1;
        rsp_seen = 0;
        run_txn(1'b1, 4'd14, 8'h00);
        check_txn(2'b01, 4'd14, 8'h00);
        check("read_rsp_pulses", 32'(rsp_seen), 32'd1);
        check("read_rsp_dat",    32'(RSP_DAT),  32'hA5);
        di_force = 1'b0;
`else
        rsp_seen = 0;
        run_txn(1'b1, 4'd2, 8'h11);
        check_txn(2'b10, 4'd2, 8'h11);
        check("no_readback_rsp", 32'(rsp_seen), 32'd0);
`endif

        // Five writes queued behind a busy FSM.
        wr_log.delete();
        send(1'b0, 4'd0, 8'h10);
        for (int i = 1; i <= 4; i++) send(1'b0, 4'(i), 8'(8'h10 + i));
        @(negedge MCLK);
        #1;
        REQ_REG = 4'd5;
        REQ_DAT = 8'h15;
        check("full_not_ready", 32'(REQ_READY), 32'd0);
        send(1'b0, 4'd5, 8'h15);
        drop_valid();
        wait_idle(3000);
        check("order_count", 32'(wr_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < wr_log.size()) check("order_data", 32'(wr_log[i]), 32'(8'h10 + i));

        // ENA held low for 100 cycles in the middle of DATA.
        ena_period = 4;
        wr_log.delete();
        send(1'b0, 4'd3, 8'h5A);
        drop_valid();
        n_wait = 0;
        while ({PSG_BDIR, PSG_BC1} != 2'b10 && n_wait < 500) begin
            @(negedge MCLK);
            n_wait++;
        end
        check("reach_data", 32'({PSG_BDIR, PSG_BC1}), 32'd2);
        ena_stop = 1'b1;
        snap     = {PSG_BDIR, PSG_BC1, PSG_DO};
        changes  = 0;
        repeat (100) begin
            @(negedge MCLK);
            if ({PSG_BDIR, PSG_BC1, PSG_DO} != snap) changes++;
        end
        check("ena_low_hold", 32'(changes), 32'd0);
        ena_stop = 1'b0;
        wait_idle(500);
        check("resume_write", 32'(wr_log.size()), 32'd1);

        // Reset during ADDR with three requests queued.
        ena_period = 8;
        send(1'b0, 4'd1, 8'h21);
        send(1'b0, 4'd2, 8'h22);
        send(1'b0, 4'd3, 8'h23);
        send(1'b0, 4'd4, 8'h24);
        drop_valid();
        check("addr_before_reset", 32'({PSG_BDIR, PSG_BC1}), 32'd3);
        RESET_L = 1'b0;
        #1;
        check("async_mode", 32'({PSG_BDIR, PSG_BC1}), 32'd0);
        check("async_do",   32'(PSG_DO),    32'd0);
        check("async_busy", 32'(BUSY),      32'd0);
        check("async_rdy",  32'(REQ_READY), 32'd0);
        repeat (3) @(negedge MCLK);
        #1;
        RESET_L = 1'b1;
        changes = 0;
        repeat (100) begin
            @(negedge MCLK);
            if ({PSG_BDIR, PSG_BC1} != 2'b00 || PSG_DO != 8'h00 || BUSY || RSP_VALID) changes++;
        end
        check("post_reset_quiet", 32'(changes), 32'd0);

        // Randomized traffic against the model.
        ena_rand = 1'b1;
        for (int k = 0; k < 250; k++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                drop_valid();
                repeat ($urandom_range(1, 12)) @(negedge MCLK);
            end
        end
        drop_valid();
        wait_idle(5000);
        repeat (4) @(negedge MCLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
